// File: rtl/div16by8_seq_if.sv
// Handshake bundle for div16by8_seq: operand side (in_*) and result side (out_*).
// The slave modport is the divider's view; master is the driver/consumer side.
interface div16by8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;
  logic        dz;

  modport master (
    output in_valid, p_in, b_in, out_ready,
    input  in_ready, out_valid, q, r, ovf, dz
  );

  modport slave (
    input  in_valid, p_in, b_in, out_ready,
    output in_ready, out_valid, q, r, ovf, dz
  );
endinterface

// File: rtl/div16by8_seq.sv
// Sequential restoring divider, 16/8 -> 8-bit quotient and remainder, one bit per clock.
// Optional macro DIV_FAST_EXIT_EN: error cases skip the 8 iterations and finish on E+1.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for operands
// S_BUSY | one restoring iteration per edge, cnt 7 down to 0
// S_SKIP | single-cycle bypass for overflow / divide-by-zero (fast exit only)
// S_DONE | out_valid high, results held until out_ready
module div16by8_seq (
  input  logic              clk,
  input  logic              rst,
  div16by8_seq_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SKIP, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_plo;
  logic [7:0]  r_b;
  logic [7:0]  r_rem;
  logic [7:0]  r_qw;
  logic [2:0]  r_cnt;
  logic [7:0]  r_q_o;
  logic [7:0]  r_r_o;
  logic        r_ovf;
  logic        r_dz;

  logic        w_accept;
  logic        w_err_in;
  logic [8:0]  w_t;
  logic [8:0]  w_diff;
  logic        w_ge;
  logic [7:0]  w_rem_next;
  logic [7:0]  w_q_next;

  // b_in == 0 also satisfies hi >= b, so one compare covers both error kinds
  assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
  assign w_err_in   = (bus.p_in[15:8] >= bus.b_in);

  assign w_t        = {r_rem, r_plo[r_cnt]};
  assign w_ge       = (w_t >= {1'b0, r_b});
  assign w_diff     = w_t - {1'b0, r_b};
  assign w_rem_next = w_ge ? w_diff[7:0] : w_t[7:0];
  assign w_q_next   = r_qw | ({7'd0, w_ge} << r_cnt);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef DIV_FAST_EXIT_EN
          w_next = w_err_in ? S_SKIP : S_BUSY;
`else
          w_next = S_BUSY;
`endif
        end
      end
      S_BUSY:  if (r_cnt == 3'd0) w_next = S_DONE;
      S_SKIP:  w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_plo <= 8'd0;
      r_b   <= 8'd0;
      r_rem <= 8'd0;
      r_qw  <= 8'd0;
      r_cnt <= 3'd0;
      r_q_o <= 8'd0;
      r_r_o <= 8'd0;
      r_ovf <= 1'b0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_plo <= bus.p_in[7:0];
            r_b   <= bus.b_in;
            r_rem <= bus.p_in[15:8];
            r_qw  <= 8'd0;
            r_cnt <= 3'd7;
            r_dz  <= (bus.b_in == 8'd0);
            r_ovf <= (bus.b_in != 8'd0) && w_err_in;
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_next;
          r_qw  <= w_q_next;
          if (r_cnt == 3'd0) begin
            // error results override whatever the iterations produced
            r_q_o <= (r_ovf || r_dz) ? 8'hFF : w_q_next;
            r_r_o <= (r_ovf || r_dz) ? 8'h00 : w_rem_next;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_SKIP: begin
          r_cnt <= 3'd0;
          r_q_o <= 8'hFF;
          r_r_o <= 8'h00;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.q         = r_q_o;
  assign bus.r         = r_r_o;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;

endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench for div16by8_seq: vector table, product sweep, hold and reset sequences.
module tb_div16by8_seq;

  logic clk;
  logic rst;
  div16by8_seq_if bus();

  div16by8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [15:0] p;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int exp_lat(logic err);
`ifdef DIV_FAST_EXIT_EN
    return err ? 1 : 8;
`else
    return 8;
`endif
  endfunction

  // Wait for out_valid, sampling 1 time unit after each rising edge; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) return;
    end
    lat = -1;
  endtask

  task automatic start_op(input logic [15:0] p, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.p_in     = p;
    bus.b_in     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.p_in     = 16'hDEAD;
    bus.b_in     = 8'hBE;
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int lat;
    start_op(v.p, v.b);
    chk({nm, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    chk({nm, ".latency"}, 32'(lat), 32'(exp_lat(v.ovf | v.dz)));
    chk({nm, ".q"},   32'(bus.q),   32'(v.q));
    chk({nm, ".r"},   32'(bus.r),   32'(v.r));
    chk({nm, ".ovf"}, 32'(bus.ovf), 32'(v.ovf));
    chk({nm, ".dz"},  32'(bus.dz),  32'(v.dz));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".in_ready_back"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".q"},   32'(bus.q),   32'd0);
    chk({nm, ".r"},   32'(bus.r),   32'd0);
    chk({nm, ".ovf"}, 32'(bus.ovf), 32'd0);
    chk({nm, ".dz"},  32'(bus.dz),  32'd0);
  endtask

  initial begin
    int lat;
    vec_t v;
    logic [7:0] a;
    logic [7:0] bb;
    logic [7:0] hq;
    logic [7:0] hr;

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{16'h7530, 8'h96, 8'hC8, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0};
    vecs[2] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 8'h12, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0};
    vecs[8] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{16'h00C8, 8'h03, 8'h42, 8'h02, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.p_in      = 16'h0000;
    bus.b_in      = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Multiplier inverse: (a*b)/b must give a with zero remainder
    for (int i = 0; i < 8; i++) begin
      a  = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(1, 255));
      v  = '{16'(a) * 16'(bb), bb, a, 8'h00, 1'b0, 1'b0};
      run_op($sformatf("prod%0d", i), v);
    end

    // Hold result with out_ready low while a new request is offered
    start_op(16'h03E8, 8'h07);
    wait_valid(lat);
    chk("hold.latency", 32'(lat), 32'd8);
    bus.in_valid = 1'b1;
    bus.p_in     = 16'h0064;
    bus.b_in     = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      hq = bus.q;
      hr = bus.r;
      chk($sformatf("hold%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d.in_ready", i),  32'(bus.in_ready),  32'd0);
      chk($sformatf("hold%0d.q", i), 32'(hq), 32'h8E);
      chk($sformatf("hold%0d.r", i), 32'(hr), 32'h06);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hold.release.out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold.release.in_ready",  32'(bus.in_ready),  32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("hold.no_stray_op", 32'(bus.out_valid), 32'd0);

    // Reset during the fourth BUSY iteration
    start_op(16'h7530, 8'h96);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("rst_busy");
    run_op("after_rst_busy", vecs[1]);

    // Reset in DONE beats simultaneous out_ready and in_valid
    start_op(16'h1234, 8'h12);
    wait_valid(lat);
    chk("rst_done.pre_ovf", 32'(bus.ovf), 32'd1);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.p_in      = 16'h0064;
    bus.b_in      = 8'h0A;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_reset_vals("rst_done");
    run_op("after_rst_done", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
